// File: rtl/istasyon_planlayici_pkg.sv
// Shared definitions for the day-plan sequencer and the station profit accumulator:
// operation codes, unit prices and the sequencer state encoding.
package istasyon_planlayici_pkg;

    localparam logic [1:0] YAKIT  = 2'b00;
    localparam logic [1:0] KAPALI = 2'b01;
    localparam logic [1:0] YIKAMA = 2'b10;
    localparam logic [1:0] MARKET = 2'b11;

    localparam int unsigned FIYAT_YAKIT  = 250;
    localparam int unsigned FIYAT_KAPALI = 0;
    localparam int unsigned FIYAT_YIKAMA = 50;
    localparam int unsigned FIYAT_MARKET = 30;

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        GONDER = 2'd1,
        BITTI  = 2'd2
    } durum_t;

    function automatic logic [31:0] birim_fiyat(input logic [1:0] kod);
        logic [31:0] fiyat;
        case (kod)
            YAKIT:   fiyat = 32'(FIYAT_YAKIT);
            KAPALI:  fiyat = 32'(FIYAT_KAPALI);
            YIKAMA:  fiyat = 32'(FIYAT_YIKAMA);
            default: fiyat = 32'(FIYAT_MARKET);
        endcase
        return fiyat;
    endfunction

endpackage

// File: rtl/istasyon_planlayici_if.sv
// Plan-load, streaming handshake and projection signals of the sequencer.
// Handshake: a day transfers on a rising saat edge where gecerli && hazir; islem_out/gun_out hold until then.
interface istasyon_planlayici_if;
    import istasyon_planlayici_pkg::*;

    logic        yaz_en;
    logic [4:0]  yaz_adres;
    logic [1:0]  yaz_veri;
    logic        basla;
    logic        hazir;
    logic        gecerli;
    logic [1:0]  islem_out;
    logic [4:0]  gun_out;
    logic        bitti;
    logic        mesgul;
    logic [31:0] tahmini_kar;
    logic [4:0]  tahmini_amorti_gunu;
    durum_t      durum;

    modport slave (
        input  yaz_en, yaz_adres, yaz_veri, basla, hazir,
        output gecerli, islem_out, gun_out, bitti, mesgul,
        output tahmini_kar, tahmini_amorti_gunu, durum
    );

    modport master (
        output yaz_en, yaz_adres, yaz_veri, basla, hazir,
        input  gecerli, islem_out, gun_out, bitti, mesgul,
        input  tahmini_kar, tahmini_amorti_gunu, durum
    );

endinterface

// File: rtl/istasyon_planlayici_kar_hesaplayici.sv
// One day's income from its operation code, plus the car-wash carry-over to the next day.
module kar_hesaplayici
    import istasyon_planlayici_pkg::*;
#(
    parameter int unsigned ARAC_SAYISI = 200
) (
    input  logic [1:0]  kod_i,
    input  logic        yikama_i,
    output logic [31:0] gelir_o,
    output logic        yikama_o
);

    // The day after a wash is billed at fuel price whatever its own code says.
    assign gelir_o  = yikama_i ? 32'(ARAC_SAYISI) * 32'(FIYAT_YAKIT)
                               : 32'(ARAC_SAYISI) * birim_fiyat(kod_i);
    assign yikama_o = yikama_i ? 1'b0 : (kod_i == YIKAMA);

endmodule

// File: rtl/istasyon_planlayici.sv
// Day-plan sequencer: holds the plan, streams one code per accepted handshake and
// keeps a shadow projection of cumulative profit and the break-even day.
module istasyon_planlayici
    import istasyon_planlayici_pkg::*;
#(
    parameter int unsigned ARAC_SAYISI = 200,
    parameter int unsigned GUN_SAYISI  = 30,
    parameter int unsigned HEDEF       = 200000
) (
    input logic                    saat,
    input logic                    reset,
    istasyon_planlayici_if.slave   bus
);

    localparam logic [4:0] SON_GUN = 5'(GUN_SAYISI);

    durum_t      durum_q, durum_d;
    logic [4:0]  gun_q, gun_d;
    logic [31:0] kar_q, kar_d;
    logic [4:0]  amorti_q, amorti_d;
    logic        yikama_q, yikama_d;
    logic [1:0]  plan_q [32];

    logic        yaz_kabul;
    logic [1:0]  islem;
    logic [31:0] gunluk_gelir;
    logic        yikama_sonraki;

    assign yaz_kabul = bus.yaz_en && (durum_q != GONDER) &&
                       (bus.yaz_adres != 5'd0) && (bus.yaz_adres <= SON_GUN);

    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) plan_q[i] <= YAKIT;
        end else if (yaz_kabul) begin
            plan_q[bus.yaz_adres] <= bus.yaz_veri;
        end
    end

    assign islem = plan_q[gun_q];

    kar_hesaplayici #(.ARAC_SAYISI(ARAC_SAYISI)) u_kar_hesaplayici (
        .kod_i    (islem),
        .yikama_i (yikama_q),
        .gelir_o  (gunluk_gelir),
        .yikama_o (yikama_sonraki)
    );

    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            durum_q  <= BOS;
            gun_q    <= 5'd1;
            kar_q    <= 32'd0;
            amorti_q <= 5'd0;
            yikama_q <= 1'b0;
        end else begin
            durum_q  <= durum_d;
            gun_q    <= gun_d;
            kar_q    <= kar_d;
            amorti_q <= amorti_d;
            yikama_q <= yikama_d;
        end
    end

    always_comb begin
        durum_d  = durum_q;
        gun_d    = gun_q;
        kar_d    = kar_q;
        amorti_d = amorti_q;
        yikama_d = yikama_q;
        case (durum_q)
            BOS, BITTI: begin
                if (bus.basla) begin
                    durum_d  = GONDER;
                    gun_d    = 5'd1;
                    kar_d    = 32'd0;
                    amorti_d = 5'd0;
                    yikama_d = 1'b0;
                end
            end
            GONDER: begin
                if (bus.hazir) begin
                    kar_d    = kar_q + gunluk_gelir;
                    yikama_d = yikama_sonraki;
                    if ((kar_d >= HEDEF) && (amorti_q == 5'd0)) amorti_d = gun_q;
                    if (gun_q == SON_GUN) durum_d = BITTI;
                    else                  gun_d   = gun_q + 5'd1;
                end
            end
            default: durum_d = BOS;
        endcase
    end

    assign bus.gecerli             = (durum_q == GONDER);
    assign bus.mesgul              = (durum_q == GONDER);
    assign bus.bitti               = (durum_q == BITTI);
    assign bus.islem_out           = islem;
    assign bus.gun_out             = gun_q;
    assign bus.tahmini_kar         = kar_q;
    assign bus.tahmini_amorti_gunu = amorti_q;
    assign bus.durum               = durum_q;

endmodule

// File: tb/tb_istasyon_planlayici.sv
// Directed and randomized bench for istasyon_planlayici against a whole-plan profit model.
module tb_istasyon_planlayici;
    import istasyon_planlayici_pkg::*;

    localparam int GUNLER = 30;
    localparam int ARAC   = 200;
    localparam int HEDEF  = 200000;

    logic saat = 1'b0;
    logic reset;
    istasyon_planlayici_if bus();

    istasyon_planlayici #(.ARAC_SAYISI(ARAC), .GUN_SAYISI(GUNLER), .HEDEF(HEDEF)) dut (
        .saat  (saat),
        .reset (reset),
        .bus   (bus)
    );

    always #5 saat = ~saat;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  plan_m   [1:GUNLER];
    int unsigned kum_m    [0:GUNLER];
    int unsigned amorti_m [0:GUNLER];
    int unsigned fiyat_tab [4] = '{250, 0, 50, 30};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cumulative profit after each day and the first day the target is met, from the plan alone.
    function automatic void projeksiyon();
        bit zorunlu = 0;
        kum_m[0]    = 0;
        amorti_m[0] = 0;
        for (int d = 1; d <= GUNLER; d++) begin
            int unsigned fiyat = zorunlu ? 250 : fiyat_tab[plan_m[d]];
            kum_m[d]    = kum_m[d-1] + ARAC * fiyat;
            amorti_m[d] = (amorti_m[d-1] != 0) ? amorti_m[d-1] : ((kum_m[d] >= HEDEF) ? d : 0);
            zorunlu     = !zorunlu && (plan_m[d] == 2'b10);
        end
    endfunction

    function automatic void model_temizle();
        for (int d = 1; d <= GUNLER; d++) plan_m[d] = 2'b00;
    endfunction

    function automatic void model_yaz(input int adr, input logic [1:0] val);
        if (adr >= 1 && adr <= GUNLER) plan_m[adr] = val;
    endfunction

    task automatic yaz(input int adr, input logic [1:0] val);
        @(negedge saat);
        bus.yaz_en    = 1'b1;
        bus.yaz_adres = 5'(adr);
        bus.yaz_veri  = val;
        @(negedge saat);
        bus.yaz_en    = 1'b0;
        model_yaz(adr, val);
    endtask

    // mod 0: hazir held high, 1: repeating 1,0,0,1, 2: random.
    task automatic calistir(input int mod, input bit basla_ile_yaz, input bit akista_yaz);
        int gun   = 1;
        int dongu = 0;
        bit h;
        @(negedge saat);
        bus.basla = 1'b1;
        if (basla_ile_yaz) begin
            bus.yaz_en    = 1'b1;
            bus.yaz_adres = 5'd1;
            bus.yaz_veri  = 2'b10;
            model_yaz(1, 2'b10);
        end
        projeksiyon();
        @(negedge saat);
        bus.basla  = 1'b0;
        bus.yaz_en = 1'b0;
        while (gun <= GUNLER && dongu < 400) begin
            chk("gecerli", 32'(bus.gecerli), 1);
            chk("mesgul", 32'(bus.mesgul), 1);
            chk("bitti_akis", 32'(bus.bitti), 0);
            chk("gun_out", 32'(bus.gun_out), gun);
            chk("islem_out", 32'(bus.islem_out), 32'(plan_m[gun]));
            chk("kar_akis", bus.tahmini_kar, kum_m[gun-1]);
            chk("amorti_akis", 32'(bus.tahmini_amorti_gunu), amorti_m[gun-1]);
            case (mod)
                0:       h = 1'b1;
                1:       h = (dongu % 4 == 0) || (dongu % 4 == 3);
                default: h = 1'($urandom_range(0, 1));
            endcase
            bus.hazir = h;
            bus.basla = (dongu == 1);
            if (akista_yaz && dongu == 0) begin
                bus.yaz_en    = 1'b1;
                bus.yaz_adres = 5'd5;
                bus.yaz_veri  = ~plan_m[5];
            end
            @(negedge saat);
            bus.yaz_en = 1'b0;
            bus.basla  = 1'b0;
            if (h) gun++;
            dongu++;
        end
        bus.hazir = 1'b0;
        chk("transfer_sayisi", 32'(gun), GUNLER + 1);
        chk("bitti_son", 32'(bus.bitti), 1);
        chk("gecerli_son", 32'(bus.gecerli), 0);
        chk("mesgul_son", 32'(bus.mesgul), 0);
        chk("kar_son", bus.tahmini_kar, kum_m[GUNLER]);
        chk("amorti_son", 32'(bus.tahmini_amorti_gunu), amorti_m[GUNLER]);
    endtask

    task automatic sifir_kontrol(input string ad);
        chk({ad, "_gecerli"}, 32'(bus.gecerli), 0);
        chk({ad, "_mesgul"}, 32'(bus.mesgul), 0);
        chk({ad, "_bitti"}, 32'(bus.bitti), 0);
        chk({ad, "_gun"}, 32'(bus.gun_out), 1);
        chk({ad, "_islem"}, 32'(bus.islem_out), 0);
        chk({ad, "_kar"}, bus.tahmini_kar, 0);
        chk({ad, "_amorti"}, 32'(bus.tahmini_amorti_gunu), 0);
        chk({ad, "_durum"}, 32'(bus.durum), 32'(BOS));
    endtask

    initial begin
        reset         = 1'b1;
        bus.yaz_en    = 1'b0;
        bus.yaz_adres = 5'd0;
        bus.yaz_veri  = 2'b00;
        bus.basla     = 1'b0;
        bus.hazir     = 1'b0;
        model_temizle();
        repeat (2) @(negedge saat);
        reset = 1'b0;
        #1;
        sifir_kontrol("reset");

        // All fuel days.
        calistir(0, 1'b0, 1'b0);
        chk("yakit_kar", bus.tahmini_kar, 1500000);
        chk("yakit_amorti", 32'(bus.tahmini_amorti_gunu), 4);

        // Odd days wash, even days closed: every even day is forced to fuel price.
        for (int d = 1; d <= GUNLER; d++) yaz(d, (d % 2 == 1) ? 2'b10 : 2'b01);
        calistir(0, 1'b0, 1'b0);
        chk("yikama_kar", bus.tahmini_kar, 900000);
        chk("yikama_amorti", 32'(bus.tahmini_amorti_gunu), 8);

        // All closed, with a stalling ready pattern.
        for (int d = 1; d <= GUNLER; d++) yaz(d, 2'b01);
        calistir(1, 1'b0, 1'b0);
        chk("kapali_kar", bus.tahmini_kar, 0);
        chk("kapali_amorti", 32'(bus.tahmini_amorti_gunu), 0);

        // Out-of-range writes, a write while streaming, and a write alongside basla in BITTI.
        yaz(0, 2'b11);
        yaz(31, 2'b11);
        calistir(0, 1'b1, 1'b1);
        chk("basla_yaz_kar", bus.tahmini_kar, 10000 + 50000);

        // Random plans with random ready.
        repeat (2) begin
            for (int d = 1; d <= GUNLER; d++) yaz(d, 2'($urandom_range(0, 3)));
            calistir(2, 1'b0, 1'b0);
        end

        // Reset after the tenth transfer, then replay with no reload.
        for (int d = 1; d <= GUNLER; d++) yaz(d, 2'($urandom_range(0, 3)));
        projeksiyon();
        @(negedge saat);
        bus.basla = 1'b1;
        @(negedge saat);
        bus.basla = 1'b0;
        bus.hazir = 1'b1;
        repeat (10) @(negedge saat);
        bus.hazir = 1'b0;
        chk("oncesi_gun", 32'(bus.gun_out), 11);
        chk("oncesi_kar", bus.tahmini_kar, kum_m[10]);
        #1 reset = 1'b1;
        #1;
        sifir_kontrol("ara_reset");
        model_temizle();
        @(negedge saat);
        reset = 1'b0;
        calistir(0, 1'b0, 1'b0);
        chk("tekrar_kar", bus.tahmini_kar, 1500000);
        chk("tekrar_amorti", 32'(bus.tahmini_amorti_gunu), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/istasyon_planlayici.md
# istasyon_planlayici

Day-plan sequencer that sits upstream of the station profit accumulator. Software or a test harness loads a 30-entry plan of daily 2-bit operation codes. On command, the block streams the codes one day at a time over a valid/ready handshake. It also maintains a shadow projection of cumulative profit and the break-even day, using the same pricing and car-wash carry-over rule as the accumulator, so both ends can be cross-checked.

## Interface
- ARAC_SAYISI, 200: vehicles per day.
- GUN_SAYISI, 30: plan length in days (1..31).
- HEDEF, 200000: break-even threshold.
- saat  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- yaz_en  input  1  plan write strobe.
- yaz_adres  input  5  day index being written (1..GUN_SAYISI).
- yaz_veri  input  2  operation code: 00 fuel, 01 closed, 10 car wash, 11 market.
- basla  input  1  start streaming (one-cycle pulse).
- hazir  input  1  downstream ready.
- gecerli  output  1  islem_out is valid.
- islem_out  output  2  code for the current day.
- gun_out  output  5  index of the current day.
- bitti  output  1  plan fully sent.
- mesgul  output  1  streaming in progress.
- tahmini_kar  output  32  projected cumulative profit, unsigned.
- tahmini_amorti_gunu  output  5  first day with profit >= HEDEF; 0 if none yet.

## Operation
- Plan memory: GUN_SAYISI x 2 bits, indexed 1..GUN_SAYISI.
- Writes:
  - Accepted only in BOS or BITTI.
  - yaz_adres of 0 or > GUN_SAYISI is ignored.
  - Writes in GONDER are ignored.
- FSM states: BOS, GONDER, BITTI.
  - BOS, basla=1 -> GONDER. Clears tahmini_kar, tahmini_amorti_gunu and the wash flag; sets day=1.
  - GONDER, transfer (gecerli && hazir) with day < GUN_SAYISI -> day+1, stay in GONDER.
  - GONDER, transfer on day == GUN_SAYISI -> BITTI.
  - BITTI, basla=1 -> GONDER with the same clearing as from BOS.
  - basla is ignored in GONDER.
- Outputs by state:
  - gecerli = mesgul = (state==GONDER).
  - bitti = (state==BITTI).
  - islem_out = plan[day] combinationally; gun_out = day.
- Projection, updated on each transfer only:
  - Wash flag set: add ARAC_SAYISI*250 regardless of code.
  - Wash flag clear: add ARAC_SAYISI times 250, 0, 50 or 30 for codes 00, 01, 10, 11 respectively.
  - New wash flag = (old flag ? 0 : code==10). A wash day forces only the next day, never a chain.
  - If the new sum >= HEDEF and tahmini_amorti_gunu==0, latch tahmini_amorti_gunu = day.
- Arithmetic: 32-bit unsigned with no saturation. The product is formed at 32 bits.

## Timing
- Reset values:
  - State BOS, day=1, wash flag 0.
  - gecerli=0, mesgul=0, bitti=0, gun_out=1.
  - tahmini_kar=0, tahmini_amorti_gunu=0.
  - Plan memory all 00.
  - islem_out = plan[1] = 00.
- basla at edge N: gecerli=1 with day 1 from after edge N.
- A write in the same cycle as basla (BOS/BITTI) is committed, and day 1 reflects it.
- Throughput: one day per cycle while hazir=1.
  - hazir=0 stalls. islem_out, gun_out, gecerli and the projection all hold.
- The projection reflects the transferred day after the transfer edge.
- The last transfer's edge also asserts bitti; gecerli drops on the same edge.
- Reset mid-stream aborts immediately:
  - All outputs and the FSM return to reset values.
  - The plan is cleared.
  - No partial state survives.

## Structure
- Shared package holds:
  - Operation code constants: YAKIT=00, KAPALI=01, YIKAMA=10, MARKET=11.
  - Per-code unit prices: 250, 0, 50, 30.
  - State enum: BOS, GONDER, BITTI.
  - The accumulator consumes the same constants.
- One sub-module, kar_hesaplayici:
  - Inputs: code and wash flag. Outputs: day income and next wash flag.
  - Reused by the accumulator side.

## Test plan
- All 30 days 00, basla, hazir=1 held -> 30 consecutive transfers, then bitti=1; tahmini_kar=1500000, tahmini_amorti_gunu=4.
- Odd days 10, even days 01 -> even days forced to 50000; amorti day 8; final tahmini_kar=900000.
- All 01 -> tahmini_kar=0, tahmini_amorti_gunu=0, bitti=1 after 30 transfers.
- hazir toggled 1,0,0,1 pattern -> gun_out and tahmini_kar hold during the low cycles; no day skipped or duplicated; total 30 transfers.
- Reset asserted after day 10 transfer -> all outputs at reset values immediately. Replaying with basla and no reload streams all 00.
- Write to address 0, address 31 and during GONDER -> plan unchanged. A write together with basla in BITTI is visible on day 1.
